// File: rtl/rpn_sequencer_if.sv
// ----------------------------------------------------------------------------
// rpn_sequencer_if
//   Bundles the board-side inputs (Enter button, DataIn switches), the
//   external ALU connection and the display/status outputs of the RPN
//   calculator sequencer.
//
//   Signals
//     Enter       button level (asynchronous to clk)
//     DataIn      WIDTH-bit operand / opcode switches
//     alu_result  WIDTH-bit combinational ALU result
//     alu_flags   FLAG_W-bit combinational ALU flags
//     alu_a       WIDTH-bit operand A register
//     alu_b       WIDTH-bit operand B register
//     alu_op      OP_W-bit opcode register
//     ToDisplay   WIDTH-bit word for the 7-segment display
//     Flags       FLAG_W-bit latched ALU flags
//     Status      3-bit state code
//
//   Modports
//     master : the sequencer (drives ALU operands and display outputs)
//     slave  : the surrounding board / ALU (drives button, switches, ALU)
// ----------------------------------------------------------------------------
interface rpn_sequencer_if #(
   parameter int WIDTH  = 16,
   parameter int OP_W   = 2,
   parameter int FLAG_W = 5
);
   logic              Enter;
   logic [WIDTH-1:0]  DataIn;
   logic [WIDTH-1:0]  alu_result;
   logic [FLAG_W-1:0] alu_flags;
   logic [WIDTH-1:0]  alu_a;
   logic [WIDTH-1:0]  alu_b;
   logic [OP_W-1:0]   alu_op;
   logic [WIDTH-1:0]  ToDisplay;
   logic [FLAG_W-1:0] Flags;
   logic [2:0]        Status;

   modport master (
      input  Enter, DataIn, alu_result, alu_flags,
      output alu_a, alu_b, alu_op, ToDisplay, Flags, Status
   );

   modport slave (
      output Enter, DataIn, alu_result, alu_flags,
      input  alu_a, alu_b, alu_op, ToDisplay, Flags, Status
   );
endinterface

// File: rtl/rpn_sequencer.sv
// ----------------------------------------------------------------------------
// rpn_sequencer
//   Control FSM for the lab RPN calculator. A single Enter button loads
//   operand A, then operand B, then an opcode from DataIn. The operands and
//   opcode are presented to an external combinational ALU; its result and
//   flags are latched one cycle later and shown until the next press (or an
//   optional display timeout).
//
//   Ports
//     clk      in   rising-edge system clock
//     reset_n  in   asynchronous active-low reset
//     bus      master modport of rpn_sequencer_if (button, switches, ALU
//              operands/result, display word, flags, status code)
//
//   Parameters
//     WIDTH         operand/result width
//     OP_W          opcode width, taken from DataIn[OP_W-1:0]
//     FLAG_W        ALU flag vector width
//     DISP_TIMEOUT  cycles spent in SHOW before returning to WAIT_A (0 = never)
// ----------------------------------------------------------------------------
module rpn_sequencer #(
   parameter int WIDTH        = 16,
   parameter int OP_W         = 2,
   parameter int FLAG_W       = 5,
   parameter int DISP_TIMEOUT = 0
) (
   input logic               clk,
   input logic               reset_n,
   rpn_sequencer_if.master   bus
);

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } state_e;

   localparam int CNT_W = (DISP_TIMEOUT > 1) ? $clog2(DISP_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      (DISP_TIMEOUT > 0) ? CNT_W'(DISP_TIMEOUT - 1) : '0;

   state_e            state_q;
   logic              enter_s1_q;
   logic              enter_s2_q;
   logic              enter_s3_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [OP_W-1:0]   op_q;
   logic [WIDTH-1:0]  result_q;
   logic [FLAG_W-1:0] flags_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              pulse_d;
   logic              timeout_d;
   logic [WIDTH-1:0]  disp_d;

   // One-cycle pulse on the synchronised rising edge of Enter; a held
   // button produces only one pulse.
   assign pulse_d = enter_s2_q & ~enter_s3_q;

   // Counter reaches CNT_LAST on the DISP_TIMEOUT-th SHOW cycle.
   assign timeout_d = (DISP_TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= WAIT_A;
         enter_s1_q <= 1'b0;
         enter_s2_q <= 1'b0;
         enter_s3_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         result_q   <= '0;
         flags_q    <= '0;
         cnt_q      <= '0;
      end else begin
         enter_s1_q <= bus.Enter;
         enter_s2_q <= enter_s1_q;
         enter_s3_q <= enter_s2_q;

         case (state_q)
            WAIT_A: begin
               if (pulse_d) begin
                  a_q     <= bus.DataIn;
                  state_q <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (pulse_d) begin
                  b_q     <= bus.DataIn;
                  state_q <= WAIT_OP;
               end
            end
            WAIT_OP: begin
               if (pulse_d) begin
                  op_q    <= bus.DataIn[OP_W-1:0];
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               // Operands have been stable on the ALU for a full cycle;
               // any button pulse arriving here is deliberately dropped.
               result_q <= bus.alu_result;
               flags_q  <= bus.alu_flags;
               cnt_q    <= '0;
               state_q  <= SHOW;
            end
            SHOW: begin
               // Pulse and timeout together still give a single exit.
               if (pulse_d || timeout_d) begin
                  flags_q <= '0;
                  state_q <= WAIT_A;
               end else if (DISP_TIMEOUT != 0) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               flags_q <= '0;
               state_q <= WAIT_A;
            end
         endcase
      end
   end

   // Display follows the switches live while an entry is awaited.
   always_comb begin
      disp_d = bus.DataIn;
      case (state_q)
         EXEC:    disp_d = a_q;
         SHOW:    disp_d = result_q;
         default: disp_d = bus.DataIn;
      endcase
   end

   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_op    = op_q;
   assign bus.ToDisplay = disp_d;
   assign bus.Flags     = flags_q;
   assign bus.Status    = state_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
module tb_rpn_sequencer;

   logic clk;
   logic rst0_n;
   logic rst8_n;
   logic chk_en;
   int   n_cmp;
   int   n_mis;

   rpn_sequencer_if #(.WIDTH(16), .OP_W(2), .FLAG_W(5)) bus0 ();
   rpn_sequencer_if #(.WIDTH(16), .OP_W(2), .FLAG_W(5)) bus1 ();

   rpn_sequencer #(.WIDTH(16), .OP_W(2), .FLAG_W(5), .DISP_TIMEOUT(0)) u_dut0 (
      .clk     (clk),
      .reset_n (rst0_n),
      .bus     (bus0)
   );

   rpn_sequencer #(.WIDTH(16), .OP_W(2), .FLAG_W(5), .DISP_TIMEOUT(8)) u_dut8 (
      .clk     (clk),
      .reset_n (rst8_n),
      .bus     (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench ALU: op 0 add, 1 sub, 2 or, 3 and; flags {N,Z,C,V,0}
   function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
      logic [16:0] w;
      logic        v;
      logic [15:0] r;
      v = 1'b0;
      case (op)
         2'd0: begin
            w = {1'b0, a} + {1'b0, b};
            v = (a[15] == b[15]) && (w[15] != a[15]);
         end
         2'd1: begin
            w = {1'b0, a} - {1'b0, b};
            v = (a[15] != b[15]) && (w[15] != a[15]);
         end
         2'd2:    w = {1'b0, a | b};
         default: w = {1'b0, a & b};
      endcase
      r = w[15:0];
      return {r[15], (r == 16'h0000), w[16], v, 1'b0, r};
   endfunction

   logic [20:0] alu0_w;
   logic [20:0] alu1_w;
   assign alu0_w          = alu_fn(bus0.alu_a, bus0.alu_b, bus0.alu_op);
   assign alu1_w          = alu_fn(bus1.alu_a, bus1.alu_b, bus1.alu_op);
   assign bus0.alu_result = alu0_w[15:0];
   assign bus0.alu_flags  = alu0_w[20:16];
   assign bus1.alu_result = alu1_w[15:0];
   assign bus1.alu_flags  = alu1_w[20:16];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model for dut0: a press "takes effect" two clocks after its
   // rising edge is first seen; the sequence position advances per press.
   int          m_phase;
   logic [15:0] m_a, m_b, m_res;
   logic [1:0]  m_op;
   logic [4:0]  m_flg;
   logic        en_prev, rose_d1, rose_d2;

   always @(posedge clk) begin
      if (!rst0_n) begin
         m_phase <= 0;
         m_a <= '0; m_b <= '0; m_op <= '0; m_res <= '0; m_flg <= '0;
         en_prev <= 1'b0; rose_d1 <= 1'b0; rose_d2 <= 1'b0;
      end else begin
         en_prev <= bus0.Enter;
         rose_d1 <= bus0.Enter & ~en_prev;
         rose_d2 <= rose_d1;
         if (m_phase == 0 && rose_d2) begin
            m_a <= bus0.DataIn; m_phase <= 1;
         end else if (m_phase == 1 && rose_d2) begin
            m_b <= bus0.DataIn; m_phase <= 2;
         end else if (m_phase == 2 && rose_d2) begin
            m_op <= bus0.DataIn[1:0]; m_phase <= 3;
         end else if (m_phase == 3) begin
            {m_flg, m_res} <= alu_fn(m_a, m_b, m_op);
            m_phase <= 4;
         end else if (m_phase == 4 && rose_d2) begin
            m_flg <= '0; m_phase <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("status", 32'(bus0.Status), 32'(m_phase));
         chk("alu_a", 32'(bus0.alu_a), 32'(m_a));
         chk("alu_b", 32'(bus0.alu_b), 32'(m_b));
         chk("alu_op", 32'(bus0.alu_op), 32'(m_op));
         chk("flags", 32'(bus0.Flags), (m_phase == 4) ? 32'(m_flg) : 32'd0);
         chk("disp", 32'(bus0.ToDisplay),
             (m_phase == 4) ? 32'(m_res) : (m_phase == 3) ? 32'(m_a) : 32'(bus0.DataIn));
      end
   end

   task automatic press(input int which, input logic [15:0] d, input int hold, input int gap);
      @(posedge clk);
      #2;
      if (which == 0) begin
         bus0.DataIn = d; bus0.Enter = 1'b1;
      end else begin
         bus1.DataIn = d; bus1.Enter = 1'b1;
      end
      repeat (hold) @(posedge clk);
      #2;
      if (which == 0) bus0.Enter = 1'b0;
      else            bus1.Enter = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int show_n;
      logic seen;
      n_cmp = 0; n_mis = 0; chk_en = 1'b0;
      rst0_n = 1'b0; rst8_n = 1'b0;
      bus0.Enter = 1'b0; bus0.DataIn = '0;
      bus1.Enter = 1'b0; bus1.DataIn = '0;
      repeat (2) @(negedge clk);
      chk("rst_status", 32'(bus0.Status), 32'd0);
      chk("rst_a", 32'(bus0.alu_a), 32'd0);
      chk("rst_flags", 32'(bus0.Flags), 32'd0);
      chk("rst8_status", 32'(bus1.Status), 32'd0);
      @(posedge clk); #2;
      rst0_n = 1'b1; rst8_n = 1'b1;
      chk_en = 1'b1;

      // 1) 0x3F + 0x12
      press(0, 16'h003F, 2, 2);
      press(0, 16'h0012, 1, 3);
      press(0, 16'h0000, 1, 1);
      repeat (3) @(negedge clk);
      chk("t1_status", 32'(bus0.Status), 32'd4);
      chk("t1_disp", 32'(bus0.ToDisplay), 32'h0051);
      chk("t1_flags", 32'(bus0.Flags), 32'd0);
      repeat (12) @(posedge clk);

      // 2) SHOW press does not load; then 0x2A - 0x7B
      press(0, 16'h1234, 1, 3);
      @(negedge clk);
      chk("t2_status", 32'(bus0.Status), 32'd0);
      chk("t2_a_kept", 32'(bus0.alu_a), 32'h003F);
      press(0, 16'h002A, 1, 2);
      press(0, 16'h007B, 1, 2);
      press(0, 16'h0001, 1, 1);
      repeat (3) @(negedge clk);
      chk("t2_disp", 32'(bus0.ToDisplay), 32'hFFAF);
      chk("t2_N", 32'(bus0.Flags[4]), 32'd1);
      press(0, 16'h0000, 1, 3);

      // 3) Long hold gives exactly one load
      press(0, 16'h0055, 20, 2);
      repeat (3) @(negedge clk);
      chk("t3_status", 32'(bus0.Status), 32'd1);
      chk("t3_a", 32'(bus0.alu_a), 32'h0055);

      // 4) Asynchronous reset mid-cycle in WAIT_OP
      press(0, 16'h0066, 1, 3);
      @(posedge clk); #3;
      chk_en = 1'b0;
      rst0_n = 1'b0;
      #1;
      chk("t4_status", 32'(bus0.Status), 32'd0);
      chk("t4_a", 32'(bus0.alu_a), 32'd0);
      chk("t4_b", 32'(bus0.alu_b), 32'd0);
      chk("t4_flags", 32'(bus0.Flags), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst0_n = 1'b1;
      @(posedge clk); #2 chk_en = 1'b1;

      // 6) Tightest possible follow-up press after the opcode
      press(0, 16'h8000, 1, 1);
      press(0, 16'h8000, 1, 1);
      press(0, 16'h0000, 1, 1);
      press(0, 16'h0009, 1, 4);
      press(0, 16'h0000, 1, 3);

      // Randomized sequences
      for (int s = 0; s < 25; s++) begin
         for (int p = 0; p < 3; p++)
            press(0, 16'($urandom), $urandom_range(1, 5), $urandom_range(1, 4));
         repeat ($urandom_range(0, 6)) @(posedge clk);
         press(0, 16'($urandom), $urandom_range(1, 4), $urandom_range(1, 4));
      end

      // 5) DISP_TIMEOUT = 8: 0x0100 & 0x0023 = 0 -> Z flag only
      press(1, 16'h0100, 1, 2);
      press(1, 16'h0023, 2, 1);
      press(1, 16'h0003, 1, 1);
      show_n = 0;
      seen   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus1.Status == 3'd4) begin
            if (!seen) begin
               chk("t5_flags_show", 32'(bus1.Flags), 32'h08);
               chk("t5_disp", 32'(bus1.ToDisplay), 32'h0000);
            end
            seen = 1'b1;
            show_n++;
         end else if (seen) begin
            break;
         end
      end
      chk("t5_show_cycles", 32'(show_n), 32'd8);
      chk("t5_status", 32'(bus1.Status), 32'd0);
      chk("t5_flags", 32'(bus1.Flags), 32'd0);
      repeat (3) @(negedge clk);
      chk("t5_stay", 32'(bus1.Status), 32'd0);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
